// File: rtl/gate_sweep_unit.sv
// Purpose: sweeps all 2^N input combinations through a selectable reduction gate and counts the high results.
// Latency: first result is valid 2 cycles after start is sampled; done is high 2^N+2 cycles after start.
// Backpressure: none; one result per cycle. start is taken only in IDLE, abort only in SWEEP.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        begin a sweep (IDLE only); mode is latched at the same edge
//   abort        end a sweep early (SWEEP only); no done pulse, count frozen
//   mode         00 OR, 01 AND, 10 XOR, 11 NOR
//   vec_out      input combination of the current result
//   gate_out     reduction of vec_out under the latched mode
//   valid        vec_out/gate_out meaningful this cycle
//   busy         sweep in progress, including the done cycle
//   done         one-cycle pulse after the final result
//   ones_count   number of high results in the current or last sweep
module gate_sweep_unit #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode,
    output logic [N-1:0] vec_out,
    output logic         gate_out,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state, state_nxt;

    // Issue stage: the FSM writes here; the output registers follow one cycle later.
    logic [N-1:0] idx, idx_nxt;
    logic [1:0]   mode_q, mode_nxt;
    logic [N-1:0] s_vec, s_vec_nxt;
    logic         s_gate, s_gate_nxt;
    logic         s_vld, s_vld_nxt;
    logic         s_done, s_done_nxt;
    logic [N:0]   s_cnt, s_cnt_nxt;

    logic         issue_gate;
    logic         last_idx;

    function automatic logic reduce_gate(input logic [1:0] m, input logic [N-1:0] v);
        logic r;
        case (m)
            2'b00:   r = |v;
            2'b01:   r = &v;
            2'b10:   r = ^v;
            default: r = ~|v;
        endcase
        return r;
    endfunction

    assign issue_gate = reduce_gate(mode_q, idx);
    assign last_idx   = (idx == '1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks the final-index transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP: begin
                if (abort)         state_nxt = IDLE;
                else if (last_idx) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue-stage next values
    always_comb begin
        idx_nxt    = idx;
        mode_nxt   = mode_q;
        s_vec_nxt  = s_vec;
        s_gate_nxt = s_gate;
        s_vld_nxt  = 1'b0;
        s_done_nxt = 1'b0;
        s_cnt_nxt  = s_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt  = mode;
                    idx_nxt   = '0;
                    s_cnt_nxt = '0;
                end
            end
            SWEEP: begin
                if (!abort) begin
                    s_vec_nxt  = idx;
                    s_gate_nxt = issue_gate;
                    s_vld_nxt  = 1'b1;
                    s_cnt_nxt  = s_cnt + {{N{1'b0}}, issue_gate};
                    // Wraps to 0 after the last index; DONE follows so it is never reissued.
                    idx_nxt    = idx + N'(1);
                end
            end
            DONE:    s_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            mode_q <= 2'b00;
            s_vec  <= '0;
            s_gate <= 1'b0;
            s_vld  <= 1'b0;
            s_done <= 1'b0;
            s_cnt  <= '0;
        end else begin
            idx    <= idx_nxt;
            mode_q <= mode_nxt;
            s_vec  <= s_vec_nxt;
            s_gate <= s_gate_nxt;
            s_vld  <= s_vld_nxt;
            s_done <= s_done_nxt;
            s_cnt  <= s_cnt_nxt;
        end
    end

    // Output registers. busy spans the delayed sweep and stays up through the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out    <= '0;
            gate_out   <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
        end else begin
            if (s_vld) begin
                vec_out  <= s_vec;
                gate_out <= s_gate;
            end
            valid      <= s_vld;
            busy       <= (state != IDLE) || s_done;
            done       <= s_done;
            ones_count <= s_cnt;
        end
    end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Purpose: directed self-checking bench for gate_sweep_unit at N=1, 3 and 8.
// Latency: checks result timing cycle by cycle against start.
// Backpressure: not applicable.
module tb_gate_sweep_unit;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [1:0] mode;

    logic [2:0] v3; logic g3, vl3, b3, d3; logic [3:0] c3;
    logic [0:0] v1; logic g1, vl1, b1, d1; logic [1:0] c1;
    logic [7:0] v8; logic g8, vl8, b8, d8; logic [8:0] c8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_sweep_unit #(.N(3)) u3 (.clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .vec_out(v3), .gate_out(g3), .valid(vl3), .busy(b3), .done(d3), .ones_count(c3));
    gate_sweep_unit #(.N(1)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .vec_out(v1), .gate_out(g1), .valid(vl1), .busy(b1), .done(d1), .ones_count(c1));
    gate_sweep_unit #(.N(8)) u8 (.clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .vec_out(v8), .gate_out(g8), .valid(vl8), .busy(b8), .done(d8), .ones_count(c8));

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        #1;
        total++; if ({v3, g3, vl3, b3, d3, c3} !== 11'd0) begin bad++; $display("FAIL reset_n3 got=%b exp=0", {v3, g3, vl3, b3, d3, c3}); end
        total++; if ({v1, g1, vl1, b1, d1, c1} !== 7'd0) begin bad++; $display("FAIL reset_n1 got=%b exp=0", {v1, g1, vl1, b1, d1, c1}); end
        total++; if ({v8, g8, vl8, b8, d8, c8} !== 21'd0) begin bad++; $display("FAIL reset_n8 got=%b exp=0", {v8, g8, vl8, b8, d8, c8}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({vl3, b3, d3} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b exp=000", {vl3, b3, d3}); end
    endtask

    task automatic test_or_sweep();
        @(negedge clk); mode = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++; if (vl3 !== (c >= 2 && c <= 9)) begin bad++; $display("FAIL or_valid c=%0d got=%b exp=%b", c, vl3, (c >= 2 && c <= 9)); end
            if (c >= 2 && c <= 9) begin
                total++; if (v3 !== 3'(c - 2)) begin bad++; $display("FAIL or_vec c=%0d got=%0d exp=%0d", c, v3, c - 2); end
                total++; if (g3 !== (c != 2)) begin bad++; $display("FAIL or_gate c=%0d got=%b exp=%b", c, g3, (c != 2)); end
            end
            total++; if (d3 !== (c == 10)) begin bad++; $display("FAIL or_done c=%0d got=%b exp=%b", c, d3, (c == 10)); end
            total++; if (b3 !== (c <= 10)) begin bad++; $display("FAIL or_busy c=%0d got=%b exp=%b", c, b3, (c <= 10)); end
            if (c == 10) begin
                total++; if (c3 !== 4'd7) begin bad++; $display("FAIL or_count got=%0d exp=7", c3); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [3:0] exp_cnt;
        ndone = 0;
        @(negedge clk); mode = 2'b01; start = 1'b1;
        @(negedge clk); mode = 2'b10;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (d3) ndone++;
            total++; if (d3 !== (c == 10 || c == 20 || c == 30)) begin bad++; $display("FAIL b2b_done c=%0d got=%b", c, d3); end
            total++; if (vl3 !== (c < 30 && (c % 10) >= 2)) begin bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, vl3, (c < 30 && (c % 10) >= 2)); end
            if (c == 10 || c == 20 || c == 30) begin
                exp_cnt = (c == 20) ? 4'd4 : 4'd1;
                total++; if (c3 !== exp_cnt) begin bad++; $display("FAIL b2b_count c=%0d got=%0d exp=%0d", c, c3, exp_cnt); end
            end
            if (c == 10) mode = 2'b11;
            if (c == 20) start = 1'b0;
        end
        total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_ndone got=%0d exp=3", ndone); end
    endtask

    task automatic test_mode_change();
        logic [7:0] xs;
        xs = 8'b1001_0110;
        @(negedge clk); mode = 2'b10; start = 1'b1;
        @(negedge clk); start = 1'b0; mode = 2'b00;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                total++; if (g3 !== xs[c - 2]) begin bad++; $display("FAIL xor_gate c=%0d got=%b exp=%b", c, g3, xs[c - 2]); end
            end
            if (c == 10) begin
                total++; if (d3 !== 1'b1) begin bad++; $display("FAIL xor_done got=%b exp=1", d3); end
                total++; if (c3 !== 4'd4) begin bad++; $display("FAIL xor_count got=%0d exp=4", c3); end
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk); mode = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) begin
                total++; if ({vl3, v3} !== 4'b1_010) begin bad++; $display("FAIL abort_last got=%b exp=1010", {vl3, v3}); end
                abort = 1'b0;
            end
            if (c >= 5) begin
                total++; if ({vl3, d3} !== 2'b00) begin bad++; $display("FAIL abort_quiet c=%0d got=%b exp=00", c, {vl3, d3}); end
                total++; if (c3 !== 4'd2) begin bad++; $display("FAIL abort_count c=%0d got=%0d exp=2", c, c3); end
            end
            if (c == 5) begin
                total++; if (b3 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", b3); end
            end
            if (c == 3) abort = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        int nres;
        @(negedge clk); mode = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        total++; if ({vl3, v3} !== 4'b1_101) begin bad++; $display("FAIL mid_pre got=%b exp=1101", {vl3, v3}); end
        #2 rst = 1'b1;
        #1;
        total++; if ({v3, g3, vl3, b3, d3, c3} !== 11'd0) begin bad++; $display("FAIL mid_reset got=%b exp=0", {v3, g3, vl3, b3, d3, c3}); end
        #1 rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if ({vl3, b3} !== 2'b00) begin bad++; $display("FAIL mid_norestart c=%0d got=%b exp=00", c, {vl3, b3}); end
        end
        nres = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (vl3) begin
                total++; if (v3 !== 3'(nres)) begin bad++; $display("FAIL mid_vec c=%0d got=%0d exp=%0d", c, v3, nres); end
                nres++;
            end
            if (c == 10) begin
                total++; if ({d3, c3} !== 5'b1_0111) begin bad++; $display("FAIL mid_final got=%b exp=10111", {d3, c3}); end
            end
        end
        total++; if (nres !== 8) begin bad++; $display("FAIL mid_nres got=%0d exp=8", nres); end
    endtask

    task automatic test_widths();
        int n1, n8;
        n1 = 0; n8 = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mode = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 262; c++) begin
            @(negedge clk);
            if (d1) begin
                n1++;
                total++; if (c !== 4) begin bad++; $display("FAIL n1_done_cycle got=%0d exp=4", c); end
                total++; if (c1 !== 2'd1) begin bad++; $display("FAIL n1_count got=%0d exp=1", c1); end
            end
            if (d8) begin
                n8++;
                total++; if (c !== 258) begin bad++; $display("FAIL n8_done_cycle got=%0d exp=258", c); end
                total++; if (c8 !== 9'd255) begin bad++; $display("FAIL n8_count got=%0d exp=255", c8); end
            end
        end
        total++; if (n1 !== 1) begin bad++; $display("FAIL n1_ndone got=%0d exp=1", n1); end
        total++; if (n8 !== 1) begin bad++; $display("FAIL n8_ndone got=%0d exp=1", n8); end
    endtask

    initial begin
        test_reset();
        test_or_sweep();
        test_back_to_back();
        test_mode_change();
        test_abort();
        test_mid_reset();
        test_widths();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
